// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side control inputs and PC/stack status outputs of the program counter.
// master drives the control strobes; slave is the pc_unit side.
interface pc_unit_if #(
  parameter int W     = 8,
  parameter int OFF_W = 8
);
  logic             stall;
  logic             jump;
  logic             branch;
  logic             call;
  logic             ret;
  logic [W-1:0]     target;
  logic [OFF_W-1:0] offset;
  logic [W-1:0]     pc;
  logic [W-1:0]     pc_next;
  logic             stk_empty;
  logic             stk_full;
  logic             err_ovf;
  logic             err_unf;
  logic             fault;

  modport master (
    output stall, jump, branch, call, ret, target, offset,
    input  pc, pc_next, stk_empty, stk_full, err_ovf, err_unf, fault
  );

  modport slave (
    input  stall, jump, branch, call, ret, target, offset,
    output pc, pc_next, stk_empty, stk_full, err_ovf, err_unf, fault
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with jump, relative branch, stall and a return-address stack.
// Define PC_ALIGN_CHK_EN to build the sticky misalignment detector driving fault.
module pc_unit #(
  parameter int W        = 8,
  parameter int STEP     = 4,
  parameter int OFF_W    = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input logic      clk,
  input logic      rst_n,
  pc_unit_if.slave bus
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [W-1:0]  STEP_V   = W'(STEP);
  localparam logic [W-1:0]  RESET_V  = W'(RESET_PC);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  pc_q;
  logic [W-1:0]  pc_d;
  logic [W-1:0]  stack [DEPTH];
  logic [PW:0]   count;
  logic [PW-1:0] top_idx;
  logic [W-1:0]  off_ext;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          set_ovf;
  logic          set_unf;
  logic          ovf_q;
  logic          unf_q;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign top_idx = count[PW-1:0] - PW'(1);
  assign off_ext = W'($signed(bus.offset));

  // pc_d folds in reset so pc_next always shows the value pc takes at the next edge
  always_comb begin
    pc_d    = pc_q + STEP_V;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (!rst_n) begin
      pc_d = RESET_V;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      if (!empty) begin
        pc_d = stack[top_idx];
        pop  = 1'b1;
      end else begin
        set_unf = 1'b1;
      end
    end else if (bus.call) begin
      pc_d = bus.target;
      if (full) set_ovf = 1'b1;
      else      push    = 1'b1;
    end else if (bus.jump) begin
      pc_d = bus.target;
    end else if (bus.branch) begin
      pc_d = pc_q + off_ext;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (!rst_n) begin
      count <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push)      count <= count + (PW+1)'(1);
      else if (pop)  count <= count - (PW+1)'(1);
      if (set_ovf)   ovf_q <= 1'b1;
      if (set_unf)   unf_q <= 1'b1;
    end
  end

  // Stack contents need no reset; the count alone defines which entries are valid
  always_ff @(posedge clk) begin
    if (push) stack[count[PW-1:0]] <= pc_q + STEP_V;
  end

`ifdef PC_ALIGN_CHK_EN
  logic fault_q;
  logic redirect;

  assign redirect = rst_n && !bus.stall &&
                    ((bus.ret && !empty) || bus.call || bus.jump || bus.branch);

  always_ff @(posedge clk) begin
    if (!rst_n)
      fault_q <= 1'b0;
    else if (redirect && ((pc_d & (STEP_V - W'(1))) != '0))
      fault_q <= 1'b1;
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.pc        = pc_q;
  assign bus.pc_next   = pc_d;
  assign bus.stk_empty = empty;
  assign bus.stk_full  = full;
  assign bus.err_ovf   = ovf_q;
  assign bus.err_unf   = unf_q;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter with absolute jump, PC-relative branch, stall, and a hardware return-address stack for call/return.
- Replaces the fixed 8-bit PC that only loads or adds 4.
- Sits at the head of the fetch path and drives the instruction address.
- Reports stack status and sticky error flags to the control/debug logic.

Parameters:
- W, 8: PC width in bits. All PC arithmetic is modulo 2^W.
- STEP, 4: Sequential increment added each active cycle.
- OFF_W, 8: Width of the signed branch offset. Must satisfy OFF_W <= W.
- DEPTH, 4: Return-stack entries. Must be a power of 2 and >= 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk, input, 1: Clock. All state updates on the rising edge.
- rst_n, input, 1: Synchronous, active-low reset.
- stall, input, 1: Hold all state this cycle.
- jump, input, 1: Absolute load, PC <= target.
- branch, input, 1: Relative branch, PC <= PC + sext(offset).
- call, input, 1: Push the return address, then PC <= target.
- ret, input, 1: Pop the top of the return stack into PC.
- target, input, W: Absolute destination for jump and call.
- offset, input, OFF_W: Signed two's-complement branch offset.
- pc, output, W: Current PC (registered).
- pc_next, output, W: Combinational value PC will take at the next edge.
- stk_empty, output, 1: Return stack has 0 entries.
- stk_full, output, 1: Return stack has DEPTH entries.
- err_ovf, output, 1: Sticky flag, set by a call while the stack is full.
- err_unf, output, 1: Sticky flag, set by a ret while the stack is empty.
- fault, output, 1: Sticky misalignment flag. Present only with PC_ALIGN_CHK_EN (see Optional Feature).

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc = RESET_PC.
  - Stack count = 0, so stk_empty = 1 and stk_full = 0.
  - err_ovf = err_unf = fault = 0.
  - Stack contents are don't-care.
  - Reset overrides every other input.
  - Reset mid-operation, e.g. asserted in the same cycle as call, discards that operation completely.
- Priority each cycle, highest first: stall > ret > call > jump > branch > increment. Exactly one action is taken per cycle.
- stall: pc, stack and flags are all held. pc_next = pc.
- ret, stack not empty: pc <= top entry; count decrements.
- ret, stack empty: pc <= pc + STEP; err_unf <= 1; count stays 0.
- call, stack not full: push (pc + STEP) mod 2^W; pc <= target; count increments.
- call, stack full: pc <= target; the push is discarded; existing entries are unchanged; err_ovf <= 1.
- jump: pc <= target.
- branch: pc <= (pc + sign-extended offset) mod 2^W.
- Otherwise: pc <= (pc + STEP) mod 2^W.
- Wrap-around: all additions truncate to W bits with no flag raised. With W = 8, pc 0xFC + 4 = 0x00.
- Latency: a control input sampled at edge N is reflected on pc after edge N. pc_next always equals the value pc will take at that edge, given the current inputs.
- Flags:
  - stk_empty and stk_full are decoded from the registered count.
  - err_ovf and err_unf stay set until reset.
- Implementation of the stack: register array plus a pointer of log2(DEPTH)+1 bits. Push and pop never occur in the same cycle, guaranteed by the priority order.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- When defined:
  - A candidate new PC from jump, call, branch or ret that is not a multiple of STEP sets sticky fault <= 1.
  - The PC update still proceeds unchanged.
  - Only meaningful when STEP is a power of 2; the check tests the low log2(STEP) bits.
- When undefined:
  - No alignment logic is built.
  - fault is tied to 0.
  - The port remains present so the interface is identical in both builds.

Test Plan:
All scenarios use W=8, STEP=4, OFF_W=8, DEPTH=4, RESET_PC=0.
- Reset then free run: hold rst_n low for 2 clocks, release, run 66 clocks.
  - pc goes 0x00, 0x04, 0x08, ...
  - pc wraps from 0xFC to 0x00.
  - With stall high for 3 clocks, pc holds its value for exactly those 3 clocks.
- Jump and branch:
  - At pc = 0x10, jump with target = 0x80 -> pc = 0x80.
  - Then branch with offset = 0xF8 (-8) -> pc = 0x78.
  - Then branch with offset = 0x10 -> pc = 0x88.
  - Asserting jump and branch together with target = 0x40 -> pc = 0x40 (jump wins).
- Nested call and return:
  - At pc = 0x20, call with target = 0x60, then at 0x64 call with target = 0xA0.
  - Two rets then give pc = 0x68 followed by pc = 0x24.
  - stk_empty = 1 at the end.
- Stack overflow: five calls in a row with the stack initially empty.
  - stk_full is set after the 4th call.
  - The 5th call still loads target and sets err_ovf = 1.
  - Four rets return the addresses pushed by calls 4, 3, 2, 1.
- Underflow and priority:
  - ret with the stack empty at pc = 0x30 -> pc = 0x34, err_unf = 1.
  - call and ret asserted together with one entry 0x50 on the stack -> pc = 0x50 (ret wins); no push occurs.
  - rst_n asserted together with call -> pc = 0x00, stack empty, both error flags cleared.
- PC_ALIGN_CHK_EN build: jump with target = 0x41.
  - pc = 0x41 and fault = 1, which stays set afterwards.
  - In a build without the macro, the same stimulus leaves fault = 0.
